// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - EX-stage branch fields, fetch prediction port and resolver status
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  logic             ex_valid;
  logic             freeze;
  logic             beq_ex;
  logic             bne_ex;
  logic             zero;
  logic [31:0]      next_pc_ex;
  logic [15:0]      imm_ex;
  logic             hit_ex;
  logic             halt_ex;
  logic [31:0]      if_pc;
  logic             if_pred_taken;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;
  logic             halted;

  modport master (
    output ex_valid, freeze, beq_ex, bne_ex, zero, next_pc_ex, imm_ex,
           hit_ex, halt_ex, if_pc,
    input  if_pred_taken, flush, redirect_valid, redirect_pc,
           branch_cnt, mispredict_cnt, halted
  );

  modport slave (
    input  ex_valid, freeze, beq_ex, bne_ex, zero, next_pc_ex, imm_ex,
           hit_ex, halt_ex, if_pc,
    output if_pred_taken, flush, redirect_valid, redirect_pc,
           branch_cnt, mispredict_cnt, halted
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - beq/bne resolution, mispredict redirect, 2-bit PHT and statistics
module branch_resolve_unit #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input logic                  CLK,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [1:0]       r_pht [ENTRIES];
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;
  logic             r_halted;

  logic             w_br;
  logic             w_taken;
  logic             w_mis;
  logic             w_halt_retire;
  logic [31:0]      w_offset;
  logic [31:0]      w_target;
  logic [31:0]      w_br_pc;
  logic [IDX_W-1:0] w_br_idx;
  logic [IDX_W-1:0] w_if_idx;
  logic [1:0]       w_cur_ctr;
  logic             w_unused;

  assign w_br          = bus.ex_valid & (bus.beq_ex | bus.bne_ex) & ~bus.freeze & ~r_halted;
  assign w_taken       = bus.beq_ex ? bus.zero : ~bus.zero;
  assign w_mis         = w_br & (w_taken != bus.hit_ex);
  assign w_halt_retire = bus.ex_valid & bus.halt_ex & ~bus.freeze;

  assign w_offset = {{14{bus.imm_ex[15]}}, bus.imm_ex, 2'b00};
  assign w_target = bus.next_pc_ex + w_offset;

  // PHT is indexed by the branch's own PC, recovered from its PC+4
  assign w_br_pc   = bus.next_pc_ex - 32'd4;
  assign w_br_idx  = w_br_pc[IDX_W+1:2];
  assign w_if_idx  = bus.if_pc[IDX_W+1:2];
  assign w_cur_ctr = r_pht[w_br_idx];

  assign w_unused = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0],
                      w_br_pc[31:IDX_W+2], w_br_pc[1:0]};

  // Fetch sees the pre-update entry when EX writes the same index this edge
  assign bus.if_pred_taken  = r_pht[w_if_idx][1];

  assign bus.flush          = w_mis & ~rst;
  assign bus.redirect_valid = w_mis & ~rst;
  assign bus.redirect_pc    = (w_mis & ~rst) ? (w_taken ? w_target : bus.next_pc_ex) : 32'd0;

  assign bus.branch_cnt     = r_branch_cnt;
  assign bus.mispredict_cnt = r_mispredict_cnt;
  assign bus.halted         = r_halted;

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_pht[i] <= 2'b01;
      end
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
      r_halted         <= 1'b0;
    end else begin
      if (w_br) begin
        if (w_taken && (w_cur_ctr != 2'b11)) begin
          r_pht[w_br_idx] <= w_cur_ctr + 2'd1;
        end else if (!w_taken && (w_cur_ctr != 2'b00)) begin
          r_pht[w_br_idx] <= w_cur_ctr - 2'd1;
        end
        r_branch_cnt <= r_branch_cnt + 1'b1;
      end
      if (w_mis) begin
        r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
      end
      if (w_halt_retire) begin
        r_halted <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized and directed checks of branch_resolve_unit against a reference model
module tb_branch_resolve_unit;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 32;

  logic CLK;
  logic rst;
  logic chk_en;

  int n_checks;
  int n_fail;

  int          m_pht [ENTRIES];
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;
  bit          m_halted;

  branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid   = 1'b0;
    bus.freeze     = 1'b0;
    bus.beq_ex     = 1'b0;
    bus.bne_ex     = 1'b0;
    bus.zero       = 1'b0;
    bus.next_pc_ex = 32'd0;
    bus.imm_ex     = 16'd0;
    bus.hit_ex     = 1'b0;
    bus.halt_ex    = 1'b0;
  endtask

  task automatic branch(input bit is_beq, input bit z, input bit hit,
                        input logic [31:0] npc, input logic [15:0] imm);
    idle();
    bus.ex_valid   = 1'b1;
    bus.beq_ex     = is_beq;
    bus.bne_ex     = !is_beq;
    bus.zero       = z;
    bus.hit_ex     = hit;
    bus.next_pc_ex = npc;
    bus.imm_ex     = imm;
  endtask

  // Reference: outputs derived from the resolution rules, then next state applied
  always @(negedge CLK) begin
    bit          br, taken, mis;
    int          idx;
    logic [31:0] target, exp_rp;
    br     = bus.ex_valid && (bus.beq_ex || bus.bne_ex) && !bus.freeze && !m_halted;
    taken  = bus.beq_ex ? bus.zero : !bus.zero;
    mis    = br && (taken != bus.hit_ex);
    target = bus.next_pc_ex + 32'($signed(bus.imm_ex)) * 32'd4;
    exp_rp = (rst || !mis) ? 32'd0 : (taken ? target : bus.next_pc_ex);
    if (chk_en) begin
      check("flush", 64'(bus.flush), 64'(mis && !rst));
      check("redirect_valid", 64'(bus.redirect_valid), 64'(mis && !rst));
      check("redirect_pc", 64'(bus.redirect_pc), 64'(exp_rp));
      check("if_pred_taken", 64'(bus.if_pred_taken), 64'(m_pht[(bus.if_pc / 4) % ENTRIES] >= 2));
      check("branch_cnt", 64'(bus.branch_cnt), 64'(m_bcnt));
      check("mispredict_cnt", 64'(bus.mispredict_cnt), 64'(m_mcnt));
      check("halted", 64'(bus.halted), 64'(m_halted));
    end
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_pht[i] = 1;
      m_bcnt   = 0;
      m_mcnt   = 0;
      m_halted = 0;
    end else begin
      if (br) begin
        idx = ((bus.next_pc_ex - 32'd4) / 4) % ENTRIES;
        if (taken) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
        else       m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
        m_bcnt++;
        if (mis) m_mcnt++;
      end
      if (bus.ex_valid && bus.halt_ex && !bus.freeze) m_halted = 1;
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    idle();
    bus.if_pc = 32'd0;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // Reset state
    bus.if_pc = 32'h40;
    #1;
    check("rst_pred", 64'(bus.if_pred_taken), 64'd0);
    check("rst_bcnt", 64'(bus.branch_cnt), 64'd0);
    check("rst_mcnt", 64'(bus.mispredict_cnt), 64'd0);
    for (int i = 0; i < ENTRIES; i++) begin
      check("rst_pht", 64'(dut.r_pht[i]), 64'd1);
      check("model_rst_pht", 64'(m_pht[i]), 64'd1);
    end

    // Mispredicted taken beq with negative offset
    step();
    branch(1'b1, 1'b1, 1'b0, 32'h104, 16'hFFFF);
    #1;
    check("s2_flush", 64'(bus.flush), 64'd1);
    check("s2_rpc", 64'(bus.redirect_pc), 64'h100);
    step();
    idle();
    bus.if_pc = 32'h100;
    #1;
    check("s2_bcnt", 64'(bus.branch_cnt), 64'd1);
    check("s2_mcnt", 64'(bus.mispredict_cnt), 64'd1);
    check("s2_pht0", 64'(dut.r_pht[0]), 64'd2);
    check("model_s2_pht0", 64'(m_pht[0]), 64'd2);
    check("s2_pred", 64'(bus.if_pred_taken), 64'd1);

    // Mispredicted not-taken bne twice, PHT[1] saturates at 0
    step();
    branch(1'b0, 1'b1, 1'b1, 32'h8, 16'h0);
    #1;
    check("s3_flush", 64'(bus.flush), 64'd1);
    check("s3_rpc", 64'(bus.redirect_pc), 64'h8);
    step();
    #1;
    check("s3_pht1_a", 64'(dut.r_pht[1]), 64'd0);
    step();
    idle();
    #1;
    check("s3_pht1_b", 64'(dut.r_pht[1]), 64'd0);
    check("s3_bcnt", 64'(bus.branch_cnt), 64'd3);
    check("s3_mcnt", 64'(bus.mispredict_cnt), 64'd3);

    // Correctly predicted beq held by freeze for three cycles
    step();
    branch(1'b1, 1'b1, 1'b1, 32'h20, 16'h4);
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s4_frz_flush", 64'(bus.flush), 64'd0);
      check("s4_frz_bcnt", 64'(bus.branch_cnt), 64'd3);
      step();
    end
    bus.freeze = 1'b0;
    #1;
    check("s4_rel_flush", 64'(bus.flush), 64'd0);
    step();
    idle();
    #1;
    check("s4_bcnt", 64'(bus.branch_cnt), 64'd4);
    check("s4_mcnt", 64'(bus.mispredict_cnt), 64'd3);

    // Halt blocks later branches until reset
    step();
    idle();
    bus.ex_valid = 1'b1;
    bus.halt_ex  = 1'b1;
    step();
    branch(1'b1, 1'b1, 1'b0, 32'h104, 16'hFFFF);
    #1;
    check("s5_halted", 64'(bus.halted), 64'd1);
    check("s5_flush", 64'(bus.flush), 64'd0);
    check("s5_rv", 64'(bus.redirect_valid), 64'd0);
    step();
    idle();
    #1;
    check("s5_bcnt", 64'(bus.branch_cnt), 64'd4);
    check("s5_mcnt", 64'(bus.mispredict_cnt), 64'd3);
    check("s5_pht0", 64'(dut.r_pht[0]), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("s5_unhalt", 64'(bus.halted), 64'd0);

    // Reset coincident with a mispredict
    step();
    branch(1'b1, 1'b1, 1'b0, 32'h104, 16'hFFFF);
    rst = 1'b1;
    #1;
    check("s6_flush", 64'(bus.flush), 64'd0);
    check("s6_rpc", 64'(bus.redirect_pc), 64'd0);
    step();
    rst = 1'b0;
    idle();
    bus.if_pc = 32'h40;
    #1;
    check("s6_bcnt", 64'(bus.branch_cnt), 64'd0);
    check("s6_mcnt", 64'(bus.mispredict_cnt), 64'd0);
    check("s6_pred", 64'(bus.if_pred_taken), 64'd0);
    for (int i = 0; i < ENTRIES; i++) check("s6_pht", 64'(dut.r_pht[i]), 64'd1);

    // Randomized traffic, checked every cycle by the reference process
    for (int c = 0; c < 3000; c++) begin
      step();
      rst            = ($urandom_range(0, 99) == 0);
      bus.ex_valid   = ($urandom_range(0, 3) != 0);
      bus.freeze     = ($urandom_range(0, 4) == 0);
      bus.beq_ex     = $urandom_range(0, 1);
      bus.bne_ex     = $urandom_range(0, 1);
      bus.zero       = $urandom_range(0, 1);
      bus.hit_ex     = $urandom_range(0, 1);
      bus.halt_ex    = ($urandom_range(0, 59) == 0);
      bus.imm_ex     = 16'($urandom);
      bus.next_pc_ex = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63)) << 2;
      bus.if_pc      = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63)) << 2;
    end
    step();
    rst = 1'b0;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
